// File: rtl/adc_frame_packer_pkg.sv
// Shared definitions for the ADC frame packer: word geometry, channel codes,
// FSM encodings and the FIFO entry layout.
package adc_frame_packer_pkg;

  localparam int ADC_WORD_W = 32;
  localparam int ADC_NUM_CH = 4;
  localparam int ADC_CH_W   = 2;

  typedef logic [ADC_CH_W-1:0] chan_t;

  localparam chan_t CH_A = 2'd0;
  localparam chan_t CH_B = 2'd1;
  localparam chan_t CH_C = 2'd2;
  localparam chan_t CH_D = 2'd3;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_PUSH = 1'b1
  } state_t;

  typedef struct packed {
    chan_t                 chan;
    logic [ADC_WORD_W-1:0] data;
  } fifo_word_t;

endpackage

// File: rtl/adc_frame_packer_fifo.sv
// First-word-fall-through synchronous FIFO. The head reads as zero while empty;
// a pop while empty is ignored, and a push while full is taken only with a pop.
module adc_sync_fifo #(
  parameter int WIDTH = 34,
  parameter int DEPTH = 8
) (
  input  logic                     adc_clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (level == '0);
  assign full    = (level == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge adc_clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  // NOTE: storage is deliberately not reset; the empty flag masks stale entries at the head.
  always_ff @(posedge adc_clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  assign head_data = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/adc_frame_packer.sv
// Deserialises four 1-bit modulator streams into 32-bit words and emits each
// A..D frame through a FWFT FIFO, counting frames dropped under backpressure.
module adc_frame_packer
  import adc_frame_packer_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int OVF_CNT_W  = 16
) (
  input  logic                          adc_clk,
  input  logic                          reset,
  input  logic                          enable,
  input  logic                          adc_a,
  input  logic                          adc_b,
  input  logic                          adc_c,
  input  logic                          adc_d,
  output logic [ADC_WORD_W-1:0]         out_data,
  output logic [ADC_CH_W-1:0]           out_chan,
  output logic                          out_last,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          ovf_sticky,
  output logic [OVF_CNT_W-1:0]          ovf_count,
  input  logic                          clear_ovf
);

  logic [ADC_NUM_CH-1:0] adc_bits;
  // Only the upper 31 bits of each shift word are kept: the oldest bit would be
  // shifted out on the completing edge, so the full word is formed straight into hold.
  logic [ADC_WORD_W-2:0] sh   [ADC_NUM_CH];
  logic [ADC_WORD_W-1:0] hold [ADC_NUM_CH];
  logic [4:0]            bit_cnt;
  state_t                state, state_n;
  chan_t                 ch, ch_n;
  logic                  frame_done;
  logic                  push;
  logic                  hold_free;
  logic                  load;
  logic                  drop;
  logic                  fifo_full;
  logic                  fifo_empty;
  fifo_word_t            push_word;
  fifo_word_t            head_word;

  assign adc_bits   = {adc_d, adc_c, adc_b, adc_a};
  assign frame_done = enable && (bit_cnt == 5'd31);
  assign push       = (state == ST_PUSH) && !fifo_full;
  assign hold_free  = (state == ST_IDLE) || ((state == ST_PUSH) && (ch == CH_D) && push);
  assign load       = frame_done && hold_free;
  assign drop       = frame_done && !hold_free;

  always_ff @(posedge adc_clk) begin
    if (reset) begin
      bit_cnt <= '0;
      for (int i = 0; i < ADC_NUM_CH; i++) sh[i] <= '0;
    end else if (enable) begin
      bit_cnt <= bit_cnt + 5'd1;
      for (int i = 0; i < ADC_NUM_CH; i++) sh[i] <= {adc_bits[i], sh[i][ADC_WORD_W-2:1]};
    end else begin
      bit_cnt <= '0;
    end
  end

  always_ff @(posedge adc_clk) begin
    if (reset) begin
      for (int i = 0; i < ADC_NUM_CH; i++) hold[i] <= '0;
    end else if (load) begin
      for (int i = 0; i < ADC_NUM_CH; i++) hold[i] <= {adc_bits[i], sh[i]};
    end
  end

  always_ff @(posedge adc_clk) begin
    if (reset) begin
      state <= ST_IDLE;
      ch    <= CH_A;
    end else begin
      state <= state_n;
      ch    <= ch_n;
    end
  end

  // NOTE: defaults are assigned first so every path drives every output and no latch is inferred.
  always_comb begin
    state_n = state;
    ch_n    = ch;
    case (state)
      ST_IDLE: begin
        if (load) begin
          state_n = ST_PUSH;
          ch_n    = CH_A;
        end
      end
      ST_PUSH: begin
        if (push) begin
          if (ch == CH_D) begin
            state_n = load ? ST_PUSH : ST_IDLE;
            ch_n    = CH_A;
          end else begin
            ch_n = ch + 1'b1;
          end
        end
      end
      default: begin
        state_n = ST_IDLE;
        ch_n    = CH_A;
      end
    endcase
  end

  // A drop coinciding with a clear restarts the count at one.
  always_ff @(posedge adc_clk) begin
    if (reset) begin
      ovf_sticky <= 1'b0;
      ovf_count  <= '0;
    end else if (drop) begin
      ovf_sticky <= 1'b1;
      if (clear_ovf)             ovf_count <= OVF_CNT_W'(1);
      else if (ovf_count != '1)  ovf_count <= ovf_count + 1'b1;
    end else if (clear_ovf) begin
      ovf_sticky <= 1'b0;
      ovf_count  <= '0;
    end
  end

  assign push_word.chan = ch;
  assign push_word.data = hold[ch];

  adc_sync_fifo #(
    .WIDTH ($bits(fifo_word_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .adc_clk   (adc_clk),
    .reset     (reset),
    .push      (push),
    .push_data (push_word),
    .pop       (out_ready),
    .head_data (head_word),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (fifo_level)
  );

  assign out_valid = !fifo_empty;
  assign out_data  = head_word.data;
  assign out_chan  = head_word.chan;
  assign out_last  = !fifo_empty && (head_word.chan == CH_D);

endmodule

// File: tb/tb_adc_frame_packer.sv
// Scoreboard bench for adc_frame_packer: expected words are queued as frames are
// driven and compared whenever the DUT hands a word over on valid&&ready.
module tb_adc_frame_packer;

  localparam int DEPTH = 8;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic          adc_clk = 1'b0;
  logic          reset = 1'b1;
  logic          enable = 1'b0;
  logic          adc_a = 1'b0, adc_b = 1'b0, adc_c = 1'b0, adc_d = 1'b0;
  logic          out_ready = 1'b0;
  logic          clear_ovf = 1'b0;
  logic [31:0]   out_data;
  logic [1:0]    out_chan;
  logic          out_last, out_valid, ovf_sticky;
  logic [LW-1:0] fifo_level;
  logic [15:0]   ovf_count;

  logic [31:0]   s_data;
  logic [1:0]    s_chan;
  logic          s_last, s_valid, s_sticky;
  logic [LW-1:0] s_level;
  logic [3:0]    s_count;

  int errors = 0;
  int checks = 0;
  logic [33:0] exp_q[$];
  logic [33:0] exp_w;

  adc_frame_packer #(.FIFO_DEPTH(DEPTH), .OVF_CNT_W(16)) dut (
    .adc_clk(adc_clk), .reset(reset), .enable(enable),
    .adc_a(adc_a), .adc_b(adc_b), .adc_c(adc_c), .adc_d(adc_d),
    .out_data(out_data), .out_chan(out_chan), .out_last(out_last),
    .out_valid(out_valid), .out_ready(out_ready), .fifo_level(fifo_level),
    .ovf_sticky(ovf_sticky), .ovf_count(ovf_count), .clear_ovf(clear_ovf)
  );

  // Narrow counter instance so saturation is reachable in a short run.
  adc_frame_packer #(.FIFO_DEPTH(DEPTH), .OVF_CNT_W(4)) dut_sat (
    .adc_clk(adc_clk), .reset(reset), .enable(enable),
    .adc_a(adc_a), .adc_b(adc_b), .adc_c(adc_c), .adc_d(adc_d),
    .out_data(s_data), .out_chan(s_chan), .out_last(s_last),
    .out_valid(s_valid), .out_ready(out_ready), .fifo_level(s_level),
    .ovf_sticky(s_sticky), .ovf_count(s_count), .clear_ovf(clear_ovf)
  );

  always #5 adc_clk = ~adc_clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1);
  end

  always @(negedge adc_clk) begin
    if (!reset && out_valid && out_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_word: got chan=%0d data=%h, required no output", out_chan, out_data);
      end else begin
        exp_w = exp_q.pop_front();
        if ({out_chan, out_data} !== exp_w || out_last !== (exp_w[33:32] == 2'd3)) begin
          errors++;
          $display("FAIL word: got chan=%0d data=%h last=%b, required chan=%0d data=%h last=%b",
                   out_chan, out_data, out_last, exp_w[33:32], exp_w[31:0], exp_w[33:32] == 2'd3);
        end
      end
    end
  end

  task automatic tick();
    @(posedge adc_clk);
    #1;
  endtask

  task automatic send_frame(input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] c, input logic [31:0] d,
                            input bit accept, input bit clr_last = 1'b0);
    if (accept) begin
      exp_q.push_back({2'd0, a});
      exp_q.push_back({2'd1, b});
      exp_q.push_back({2'd2, c});
      exp_q.push_back({2'd3, d});
    end
    for (int i = 0; i < 32; i++) begin
      enable    = 1'b1;
      adc_a     = a[i];
      adc_b     = b[i];
      adc_c     = c[i];
      adc_d     = d[i];
      clear_ovf = clr_last && (i == 31);
      tick();
    end
    clear_ovf = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    enable    = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 300 && (exp_q.size() != 0 || out_valid); i++) tick();
    checks++;
    if (exp_q.size() != 0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL %s_drain: got %0d words pending valid=%b, required 0 pending valid=0",
               name, exp_q.size(), out_valid);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    checks++;
    if ({out_valid, out_last, out_chan, out_data} !== '0) begin
      errors++;
      $display("FAIL reset_stream: got valid=%b last=%b chan=%0d data=%h, required all 0",
               out_valid, out_last, out_chan, out_data);
    end
    checks++;
    if (fifo_level !== '0) begin
      errors++;
      $display("FAIL reset_level: got %0d, required 0", fifo_level);
    end
    checks++;
    if ({ovf_sticky, ovf_count} !== '0) begin
      errors++;
      $display("FAIL reset_ovf: got sticky=%b count=%0d, required 0/0", ovf_sticky, ovf_count);
    end
  endtask

  task automatic test_pattern();
    out_ready = 1'b1;
    send_frame(32'hABCDEF01, 32'hFFFFFFFF, 32'h00000000, 32'h55555555, 1'b1);
    enable = 1'b0;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL latency_early: got valid=%b on completing edge, required 0", out_valid);
    end
    tick();
    checks++;
    if (out_valid !== 1'b1 || fifo_level !== LW'(1)) begin
      errors++;
      $display("FAIL latency_first: got valid=%b level=%0d, required valid=1 level=1", out_valid, fifo_level);
    end
    checks++;
    if (out_data !== 32'hABCDEF01 || out_chan !== 2'd0 || out_last !== 1'b0) begin
      errors++;
      $display("FAIL first_head: got data=%h chan=%0d last=%b, required abcdef01/0/0",
               out_data, out_chan, out_last);
    end
    wait_drain("pattern");
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1;
    for (int f = 0; f < 100; f++)
      send_frame($urandom, $urandom, $urandom, $urandom, 1'b1);
    wait_drain("back_to_back");
    checks++;
    if (ovf_count !== 16'd0 || ovf_sticky !== 1'b0) begin
      errors++;
      $display("FAIL b2b_no_drop: got count=%0d sticky=%b, required 0/0", ovf_count, ovf_sticky);
    end
  endtask

  task automatic test_enable_toggle();
    out_ready = 1'b1;
    for (int i = 0; i < 17; i++) begin
      enable = 1'b1;
      {adc_a, adc_b, adc_c, adc_d} = 4'($urandom);
      tick();
    end
    enable = 1'b0;
    {adc_a, adc_b, adc_c, adc_d} = 4'hF;
    repeat (3) tick();
    checks++;
    if (out_valid !== 1'b0 || fifo_level !== '0) begin
      errors++;
      $display("FAIL partial_frame: got valid=%b level=%0d, required 0/0", out_valid, fifo_level);
    end
    send_frame(32'h12345678, 32'h9ABCDEF0, 32'h0F0F0F0F, 32'hF00DCAFE, 1'b1);
    wait_drain("enable_toggle");
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    send_frame(32'h11111111, 32'h11112222, 32'h11113333, 32'h11114444, 1'b1);
    send_frame(32'h22221111, 32'h22222222, 32'h22223333, 32'h22224444, 1'b1);
    send_frame(32'h33331111, 32'h33332222, 32'h33333333, 32'h33334444, 1'b1);
    send_frame(32'h44441111, 32'h44442222, 32'h44443333, 32'h44444444, 1'b0);
    checks++;
    if (fifo_level !== LW'(8)) begin
      errors++;
      $display("FAIL bp_level: got %0d, required 8", fifo_level);
    end
    checks++;
    if (ovf_count !== 16'd1 || ovf_sticky !== 1'b1) begin
      errors++;
      $display("FAIL bp_drop: got count=%0d sticky=%b, required 1/1", ovf_count, ovf_sticky);
    end
    checks++;
    if (out_data !== 32'h11111111 || out_chan !== 2'd0) begin
      errors++;
      $display("FAIL bp_head: got data=%h chan=%0d, required 11111111/0", out_data, out_chan);
    end
    wait_drain("backpressure");
  endtask

  task automatic test_clear_race();
    out_ready = 1'b0;
    send_frame(32'hA0000001, 32'hA0000002, 32'hA0000003, 32'hA0000004, 1'b1);
    send_frame(32'hB0000001, 32'hB0000002, 32'hB0000003, 32'hB0000004, 1'b1);
    send_frame(32'hC0000001, 32'hC0000002, 32'hC0000003, 32'hC0000004, 1'b1);
    send_frame(32'hD0000001, 32'hD0000002, 32'hD0000003, 32'hD0000004, 1'b0, 1'b1);
    checks++;
    if (ovf_count !== 16'd1 || ovf_sticky !== 1'b1) begin
      errors++;
      $display("FAIL clear_race: got count=%0d sticky=%b, required 1/1", ovf_count, ovf_sticky);
    end
    enable    = 1'b0;
    clear_ovf = 1'b1;
    tick();
    clear_ovf = 1'b0;
    checks++;
    if (ovf_count !== 16'd0 || ovf_sticky !== 1'b0) begin
      errors++;
      $display("FAIL clear_alone: got count=%0d sticky=%b, required 0/0", ovf_count, ovf_sticky);
    end
  endtask

  task automatic test_saturation();
    out_ready = 1'b0;
    for (int f = 0; f < 20; f++)
      send_frame($urandom, $urandom, $urandom, $urandom, 1'b0);
    checks++;
    if (ovf_count !== 16'd20) begin
      errors++;
      $display("FAIL drop_count: got %0d, required 20", ovf_count);
    end
    checks++;
    if (s_count !== 4'hF || s_sticky !== 1'b1) begin
      errors++;
      $display("FAIL saturate: got count=%h sticky=%b, required f/1", s_count, s_sticky);
    end
    wait_drain("saturation");
  endtask

  task automatic test_reset_mid_push();
    out_ready = 1'b0;
    send_frame(32'hE0000001, 32'hE0000002, 32'hE0000003, 32'hE0000004, 1'b1);
    send_frame(32'hF0000001, 32'hF0000002, 32'hF0000003, 32'hF0000004, 1'b1);
    enable = 1'b0;
    tick();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    checks++;
    if (fifo_level !== LW'(5)) begin
      errors++;
      $display("FAIL mid_push_setup: got level %0d, required 5", fifo_level);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    exp_q.delete();
    checks++;
    if ({out_valid, out_last, out_chan, out_data, fifo_level, ovf_sticky, ovf_count} !== '0) begin
      errors++;
      $display("FAIL mid_reset_outputs: got valid=%b level=%0d data=%h sticky=%b count=%0d, required all 0",
               out_valid, fifo_level, out_data, ovf_sticky, ovf_count);
    end
    out_ready = 1'b1;
    repeat (6) tick();
    checks++;
    if (out_valid !== 1'b0 || fifo_level !== '0) begin
      errors++;
      $display("FAIL mid_reset_idle: got valid=%b level=%0d, required 0/0", out_valid, fifo_level);
    end
    send_frame(32'h0BADF00D, 32'hDEADBEEF, 32'hCAFEBABE, 32'h8BADF00D, 1'b1);
    wait_drain("reset_mid_push");
  endtask

  initial begin
    test_reset();
    test_pattern();
    test_back_to_back();
    test_enable_toggle();
    test_backpressure();
    test_clear_race();
    test_saturation();
    test_reset_mid_push();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
